// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: reset address, FSM encoding, fetch FIFO entry layout.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetch FIFO of {instr, pc} entries; head visible the cycle after push, push+pop on full legal.
// Backpressure: caller must not push when full unless popping in the same cycle.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: the top masks the head while empty.
  always_ff @(posedge i_clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch.sv
// PC/issue front end: word reads to 1-cycle imem, first o_valid 2 cycles after o_imem_ren, 1 instr/cycle.
// Issue is credit-limited by FIFO space; FETCH_MISALIGN_CHK_EN halts on a misaligned redirect target.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        o_misalign,
`endif
  output logic        o_halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          run_en;
  logic          in_run;
  logic          pop;
  logic          flush;
  logic          squash;
  logic          go_halt;
  logic          bad_target;
  logic          issue;
  logic          push;
  logic [CW:0]   credit_used;
  logic [CW:0]   credit_avail;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  head;
  fetch_entry_t  push_dat;

  assign in_run = (state == ST_RUN);
  assign pop    = o_valid & i_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  assign bad_target = i_redirect & (i_redirect_pc[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  assign flush   = in_run & (i_halt | i_redirect);
  assign go_halt = in_run & (i_halt | bad_target);
  // The response landing this cycle belongs to the old stream.
  assign squash  = flush;

  assign credit_used  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign credit_avail = DEPTH_W + {{CW{1'b0}}, pop};
  assign issue        = run_en & in_run & ~i_halt & ~i_redirect & (credit_used < credit_avail);

  assign o_imem_ren   = issue;
  assign o_imem_raddr = issue ? pc : '0;

  assign push           = inflight & ~squash & (~fifo_full | pop);
  assign push_dat.instr = i_imem_rdata;
  assign push_dat.pc    = inflight_pc;

  assign o_valid  = ~fifo_empty;
  assign o_instr  = fifo_empty ? '0 : head.instr;
  assign o_pc     = fifo_empty ? '0 : head.pc;
  assign o_halted = (state == ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      run_en      <= 1'b0;
    end else begin
      // Issue begins the cycle after reset release.
      run_en   <= 1'b1;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
      if (go_halt) begin
        state <= ST_HALTED;
      end else if (flush) begin
        pc <= word_align(i_redirect_pc);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misalign <= 1'b0;
    end else if (in_run && bad_target && !i_halt) begin
      o_misalign <= 1'b1;
    end
  end
`endif

  instr_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a stream-level reference model checked every cycle.
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_halted;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        o_misalign;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .RESET_ADDR (32'h0000_0000),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_ren    (o_imem_ren),
    .o_imem_raddr  (o_imem_raddr),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
`ifdef FETCH_MISALIGN_CHK_EN
    .o_misalign    (o_misalign),
`endif
    .o_halted      (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word at addr reads back as addr ^ KEY one cycle later.
  always @(posedge clk) begin
    if (o_imem_ren) i_imem_rdata <= o_imem_raddr ^ KEY;
    else            i_imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each issued word becomes visible two cycles after issue,
  // delivered in address order; redirect/halt discards everything outstanding.
  longint      cyc_n = 0;
  longint      due_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_exp_pc;
  logic        m_halted;
  logic        m_mis;
  logic        m_armed;
  logic        exp_valid;
  logic        exp_ren;
  logic        m_pop;
  logic        m_flush;

  initial begin
    m_fetch_pc = 32'h0; m_exp_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_armed = 1'b0;
  end

  always @(negedge clk) begin
    #4;
    cyc_n++;
    if (!rst_n) begin
      chk("rst_ren", {31'b0, o_imem_ren}, 32'h0);
      chk("rst_raddr", o_imem_raddr, 32'h0);
      chk("rst_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_halted", {31'b0, o_halted}, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("rst_misalign", {31'b0, o_misalign}, 32'h0);
`endif
      due_q.delete();
      m_fetch_pc = 32'h0; m_exp_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_armed = 1'b0;
    end else begin
      exp_valid = (due_q.size() > 0) && (due_q[0] <= cyc_n);
      m_pop     = exp_valid && i_ready;
      m_flush   = !m_halted && (i_halt || i_redirect);
      exp_ren   = m_armed && !m_halted && !m_flush &&
                  (due_q.size() < DEPTH + (m_pop ? 1 : 0));
      chk("m_valid", {31'b0, o_valid}, {31'b0, exp_valid});
      chk("m_ren", {31'b0, o_imem_ren}, {31'b0, exp_ren});
      chk("m_halted", {31'b0, o_halted}, {31'b0, m_halted});
`ifdef FETCH_MISALIGN_CHK_EN
      chk("m_misalign", {31'b0, o_misalign}, {31'b0, m_mis});
`endif
      if (exp_ren) chk("m_raddr", o_imem_raddr, m_fetch_pc);
      if (exp_valid) begin
        chk("m_pc", o_pc, m_exp_pc);
        chk("m_instr", o_instr, m_exp_pc ^ KEY);
      end else begin
        chk("m_pc_idle", o_pc, 32'h0);
        chk("m_instr_idle", o_instr, 32'h0);
      end
      if (m_pop) begin
        void'(due_q.pop_front());
        m_exp_pc = m_exp_pc + 32'd4;
      end
      if (m_flush) begin
        due_q.delete();
        if (i_halt) begin
          m_halted = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
        end else if (i_redirect_pc[1:0] != 2'b00) begin
          m_halted = 1'b1;
          m_mis    = 1'b1;
`endif
        end else begin
          m_fetch_pc = i_redirect_pc & ~32'h3;
          m_exp_pc   = i_redirect_pc & ~32'h3;
        end
      end else if (exp_ren) begin
        due_q.push_back(cyc_n + 2);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_armed = 1'b1;
    end
  end

  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc, input logic hl);
    @(negedge clk);
    i_ready = rdy; i_redirect = rd; i_redirect_pc = rpc; i_halt = hl;
    #4;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;
    #4;
    chk("reset_valid", {31'b0, o_valid}, 32'h0);
    chk("reset_ren", {31'b0, o_imem_ren}, 32'h0);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #4;
  endtask

  initial begin
    rst_n = 1'b0; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;

    // Streaming fetch with decode always ready.
    hold_reset(); release_reset();
    step(1, 0, 0, 0); chk("t1_ren", {31'b0, o_imem_ren}, 32'h1); chk("t1_addr0", o_imem_raddr, 32'h0);
    step(1, 0, 0, 0); chk("t1_no_valid_yet", {31'b0, o_valid}, 32'h0); chk("t1_addr4", o_imem_raddr, 32'h4);
    step(1, 0, 0, 0); chk("t1_first_valid", {31'b0, o_valid}, 32'h1); chk("t1_pc0", o_pc, 32'h0);
    chk("t1_instr0", o_instr, 32'hA5A5_0000); chk("t1_addr8", o_imem_raddr, 32'h8);
    step(1, 0, 0, 0); chk("t1_pc4", o_pc, 32'h4);
    step(1, 0, 0, 0); chk("t1_pc8", o_pc, 32'h8); chk("t1_instr8", o_instr, 32'hA5A5_0008);

    // Decode stalls for five cycles after taking the first instruction.
    hold_reset(); release_reset();
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("t2_pc0", o_pc, 32'h0);
    step(0, 0, 0, 0); chk("t2_head4", o_pc, 32'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("t2_stall_ren", {31'b0, o_imem_ren}, 32'h0); chk("t2_stall_head", o_pc, 32'h4);
    chk("t2_stall_valid", {31'b0, o_valid}, 32'h1);
    step(1, 0, 0, 0); chk("t2_rel_pc4", o_pc, 32'h4); chk("t2_rel_addrC", o_imem_raddr, 32'hC);
    step(1, 0, 0, 0); chk("t2_rel_pc8", o_pc, 32'h8);
    step(1, 0, 0, 0); chk("t2_rel_pcC", o_pc, 32'hC);

    // Redirect while a word is in flight, then halt+redirect together.
    hold_reset(); release_reset();
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 32'h100, 0); chk("t3_redir_ren", {31'b0, o_imem_ren}, 32'h0); chk("t3_redir_pc0", o_pc, 32'h0);
    step(1, 0, 0, 0); chk("t3_addr100", o_imem_raddr, 32'h100); chk("t3_no_stale", {31'b0, o_valid}, 32'h0);
    step(1, 0, 0, 0); chk("t3_addr104", o_imem_raddr, 32'h104);
    step(1, 0, 0, 0); chk("t3_pc100", o_pc, 32'h100); chk("t3_instr100", o_instr, 32'hA5A5_0100);
    step(1, 1, 32'h200, 1); chk("t4_ren", {31'b0, o_imem_ren}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("t4_halted", {31'b0, o_halted}, 32'h1);
      chk("t4_ren_off", {31'b0, o_imem_ren}, 32'h0);
      chk("t4_valid_off", {31'b0, o_valid}, 32'h0);
    end

    // PC wraps past the top of the address space.
    hold_reset(); release_reset();
    step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0); chk("t5_addr_top", o_imem_raddr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0); chk("t5_addr_wrap", o_imem_raddr, 32'h0); chk("t5_ren_wrap", {31'b0, o_imem_ren}, 32'h1);
    step(1, 0, 0, 0); chk("t5_pc_top", o_pc, 32'hFFFF_FFFC); chk("t5_instr_top", o_instr, 32'h5A5A_FFFC);
    step(1, 0, 0, 0); chk("t5_pc_wrap", o_pc, 32'h0);

    // Misaligned redirect target.
    hold_reset(); release_reset();
    step(1, 0, 0, 0);
    step(1, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    step(1, 0, 0, 0); chk("t6_misalign", {31'b0, o_misalign}, 32'h1); chk("t6_halted", {31'b0, o_halted}, 32'h1);
    step(1, 0, 0, 0); chk("t6_ren_off", {31'b0, o_imem_ren}, 32'h0);
`else
    step(1, 0, 0, 0); chk("t6_addr100", o_imem_raddr, 32'h100);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("t6_pc100", o_pc, 32'h100);
`endif

    // Asynchronous reset in the middle of a stream.
    hold_reset(); release_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_ren", {31'b0, o_imem_ren}, 32'h0); chk("t7_async_valid", {31'b0, o_valid}, 32'h0);
    chk("t7_async_pc", o_pc, 32'h0); chk("t7_async_instr", o_instr, 32'h0);
    release_reset();
    step(1, 0, 0, 0); chk("t7_restart_addr", o_imem_raddr, 32'h0); chk("t7_restart_ren", {31'b0, o_imem_ren}, 32'h1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("t7_restart_pc", o_pc, 32'h0); chk("t7_restart_valid", {31'b0, o_valid}, 32'h1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
